// File: rtl/tile_line_renderer.sv
// rtl/tile_line_renderer.sv - tile-map line renderer with double line buffer and map fetch FSM
module tile_line_renderer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BLOCK_BITS    = 4,
  parameter int COLOR_BITS    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pixel_read,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  output logic [COLOR_BITS-1:0] cor,
  output logic [9:0]            mapa_x,
  output logic [9:0]            mapa_y,
  output logic                  mapa_read,
  input  logic                  mapa_valid,
  input  logic [COLOR_BITS-1:0] mapa_cor,
  output logic                  underrun
);

  localparam int TILES_X = SCREEN_WIDTH >> BLOCK_BITS;
  localparam int TILES_Y = SCREEN_HEIGHT >> BLOCK_BITS;
  localparam int COL_W   = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int ROW_W   = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                  state;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        frow;
  logic [COLOR_BITS-1:0]   line_buf [2][TILES_X];

  logic [9:0]              tile_x;
  logic [9:0]              tile_y;
  logic                    row_trigger;
  logic                    last_row;
  logic                    row_ready;
  logic                    accept;
  logic                    unused_tile_x;

  assign tile_x        = pixel_x >> BLOCK_BITS;
  assign tile_y        = pixel_y >> BLOCK_BITS;
  assign unused_tile_x = ^tile_x[9:COL_W];

  // A new tile row begins on the first pixel of its first scan line
  assign row_trigger = pixel_read && (pixel_x == 10'd0) && (pixel_y[BLOCK_BITS-1:0] == '0);
  assign last_row    = ({22'd0, tile_y} + 32'd1) >= 32'(TILES_Y);

  // The row about to be shown is ready only if its own fetch ran to completion
  assign row_ready = (state == DONE) && (frow == tile_y[ROW_W-1:0]);
  assign accept    = (state == FETCH) && mapa_read && mapa_valid;

  assign mapa_x = {{(10-COL_W){1'b0}}, col};
  assign mapa_y = {{(10-ROW_W){1'b0}}, frow};

  // Fetch FSM: frame_start beats row triggers; every new fetch starts with read low for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      frow      <= '0;
      mapa_read <= 1'b0;
      underrun  <= 1'b0;
    end else if (frame_start) begin
      state     <= FETCH;
      col       <= '0;
      frow      <= '0;
      mapa_read <= 1'b0;
    end else if (row_trigger) begin
      if (!row_ready) underrun <= 1'b1;
      col       <= '0;
      mapa_read <= 1'b0;
      if (last_row) begin
        state <= IDLE;
      end else begin
        state <= FETCH;
        frow  <= tile_y[ROW_W-1:0] + ROW_W'(1);
      end
    end else begin
      case (state)
        FETCH: begin
          if (mapa_read) begin
            if (mapa_valid) begin
              mapa_read <= 1'b0;
              if (col == COL_W'(TILES_X - 1)) state <= DONE;
              else col <= col + COL_W'(1);
            end
          end else begin
            mapa_read <= 1'b1;
          end
        end
        default: mapa_read <= 1'b0;
      endcase
    end
  end

  // Line buffer write: only a request that completes without being aborted lands in the buffer
  always_ff @(posedge clk) begin
    if (!reset && !frame_start && !row_trigger && accept) begin
      line_buf[frow[0]][col] <= mapa_cor;
    end
  end

  // Pixel path: one-cycle lookup of the tile colour, black outside active pixels
  always_ff @(posedge clk) begin
    if (reset) begin
      cor <= '0;
    end else if (pixel_read) begin
      cor <= line_buf[tile_y[0]][tile_x[COL_W-1:0]];
    end else begin
      cor <= '0;
    end
  end

endmodule

// File: tb/tb_tile_line_renderer.sv
// tb/tb_tile_line_renderer.sv - self-checking bench for tile_line_renderer
module tb_tile_line_renderer;

  localparam int SW = 64;
  localparam int SH = 32;
  localparam int BB = 3;
  localparam int CB = 6;
  localparam int TX = 8;
  localparam int TY = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          pixel_read = 1'b0;
  logic [9:0]    pixel_x = 10'd0;
  logic [9:0]    pixel_y = 10'd0;
  logic [CB-1:0] cor;
  logic [9:0]    mapa_x;
  logic [9:0]    mapa_y;
  logic          mapa_read;
  logic          mapa_valid = 1'b0;
  logic [CB-1:0] mapa_cor = '0;
  logic          underrun;

  int errors = 0;
  int checks = 0;

  int resp_en = 1;
  int resp_delay = 0;
  int rand_delay = 0;
  int strict = 0;
  int unstable = 0;
  int gap_err = 0;
  logic [19:0] hs_q [$];

  logic [CB-1:0] exp_buf [2][TX];

  bit          r_waiting = 0;
  bit          r_just_acc = 0;
  logic [19:0] r_held = '0;
  int          r_cnt = 0;
  int          r_dly = 0;

  tile_line_renderer #(
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BLOCK_BITS(BB), .COLOR_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_read(pixel_read),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .cor(cor), .mapa_x(mapa_x), .mapa_y(mapa_y),
    .mapa_read(mapa_read), .mapa_valid(mapa_valid), .mapa_cor(mapa_cor), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [CB-1:0] color(input int x, input int y);
    return CB'(8 * y + x);
  endfunction

  // number of differences between logged requests and the full row (0..7, row)
  function automatic int seq_diff(input int row);
    int d = 0;
    if (hs_q.size() != TX) d++;
    for (int i = 0; i < hs_q.size() && i < TX; i++)
      if (hs_q[i] !== {10'(i), 10'(row)}) d++;
    return d;
  endfunction

  task automatic load_model(input int row);
    for (int c = 0; c < TX; c++) exp_buf[row % 2][c] = color(c, row);
  endtask

  // map memory: answers each request after a delay, logs accepted addresses
  initial begin
    forever begin
      @(negedge clk);
      if (r_just_acc && mapa_read) gap_err++;
      r_just_acc = 0;
      if (mapa_read) begin
        if (r_waiting && {mapa_x, mapa_y} !== r_held) unstable++;
        if (!r_waiting) begin
          r_waiting = 1;
          r_held = {mapa_x, mapa_y};
          r_cnt = 0;
          r_dly = (rand_delay != 0) ? int'($urandom_range(0, 4)) : resp_delay;
        end
        if (resp_en != 0 && r_cnt >= r_dly) begin
          mapa_valid = 1'b1;
          mapa_cor = color(int'(mapa_x), int'(mapa_y));
          hs_q.push_back(r_held);
          r_waiting = 0;
          r_just_acc = 1;
        end else begin
          mapa_valid = 1'b0;
          r_cnt++;
        end
      end else begin
        if (r_waiting && strict != 0) unstable++;
        r_waiting = 0;
        mapa_valid = 1'b0;
        mapa_cor = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hs(input int n, output bit ok);
    int b = 0;
    while (hs_q.size() < n && b < 200) begin
      @(negedge clk);
      b++;
    end
    ok = (hs_q.size() >= n);
  endtask

  task automatic pulse_frame;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y, output logic [CB-1:0] c);
    @(negedge clk);
    pixel_read = 1'b1;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    @(negedge clk);
    c = cor;
    pixel_read = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    checks++; if (mapa_read !== 1'b0) begin errors++; $display("FAIL reset_mapa_read got %b want 0", mapa_read); end
    checks++; if (mapa_x !== 10'd0) begin errors++; $display("FAIL reset_mapa_x got %0d want 0", mapa_x); end
    checks++; if (mapa_y !== 10'd0) begin errors++; $display("FAIL reset_mapa_y got %0d want 0", mapa_y); end
    checks++; if (cor !== '0) begin errors++; $display("FAIL reset_cor got %0d want 0", cor); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    reset = 1'b0;
    tick(3);
    checks++; if (mapa_read !== 1'b0) begin errors++; $display("FAIL idle_no_request got %b want 0", mapa_read); end
  endtask

  task automatic test_first_row;
    bit ok;
    logic [CB-1:0] c;
    int x, y;
    resp_delay = 0;
    hs_q.delete();
    pulse_frame();
    wait_hs(TX, ok);
    tick(4);
    checks++; if (!ok) begin errors++; $display("FAIL row0_fetch_timeout got %0d requests want %0d", hs_q.size(), TX); end
    checks++; if (seq_diff(0) !== 0) begin errors++; $display("FAIL row0_sequence diffs=%0d want 0 (n=%0d)", seq_diff(0), hs_q.size()); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL row0_gap got %0d want 0", gap_err); end
    load_model(0);
    pix(17, 3, c);
    checks++; if (c !== 6'd2) begin errors++; $display("FAIL pixel_17_3 got %0d want 2", c); end
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(1, SW - 1));
      y = int'($urandom_range(0, 7));
      pix(x, y, c);
      checks++; if (c !== exp_buf[(y >> BB) % 2][x >> BB]) begin errors++; $display("FAIL row0_random (%0d,%0d) got %0d want %0d", x, y, c, exp_buf[(y >> BB) % 2][x >> BB]); end
    end
  endtask

  task automatic test_row_trigger;
    bit ok;
    logic [CB-1:0] c;
    int x, y;
    hs_q.delete();
    pix(0, 0, c);
    checks++; if (c !== exp_buf[0][0]) begin errors++; $display("FAIL trig0_cor got %0d want %0d", c, exp_buf[0][0]); end
    wait_hs(TX, ok);
    tick(4);
    checks++; if (!ok || seq_diff(1) !== 0) begin errors++; $display("FAIL row1_sequence diffs=%0d want 0 (n=%0d)", seq_diff(1), hs_q.size()); end
    load_model(1);
    hs_q.delete();
    pix(0, 8, c);
    checks++; if (c !== exp_buf[1][0]) begin errors++; $display("FAIL trig8_cor got %0d want %0d", c, exp_buf[1][0]); end
    wait_hs(TX, ok);
    tick(4);
    checks++; if (!ok || seq_diff(2) !== 0) begin errors++; $display("FAIL row2_sequence diffs=%0d want 0 (n=%0d)", seq_diff(2), hs_q.size()); end
    load_model(2);
    pix(63, 9, c);
    checks++; if (c !== 6'd15) begin errors++; $display("FAIL pixel_63_9 got %0d want 15", c); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL row_trigger_underrun got %b want 0", underrun); end
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(1, SW - 1));
      y = int'($urandom_range(8, 23));
      pix(x, y, c);
      checks++; if (c !== exp_buf[(y >> BB) % 2][x >> BB]) begin errors++; $display("FAIL rows12_random (%0d,%0d) got %0d want %0d", x, y, c, exp_buf[(y >> BB) % 2][x >> BB]); end
    end
  endtask

  task automatic test_delayed;
    bit ok;
    logic [CB-1:0] c;
    int x, y;
    resp_delay = 3;
    strict = 1;
    unstable = 0;
    gap_err = 0;
    hs_q.delete();
    pulse_frame();
    wait_hs(TX, ok);
    tick(8);
    checks++; if (!ok || seq_diff(0) !== 0) begin errors++; $display("FAIL delayed_sequence diffs=%0d want 0 (n=%0d)", seq_diff(0), hs_q.size()); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL delayed_hold_stable got %0d glitches want 0", unstable); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL delayed_gap got %0d want 0", gap_err); end
    checks++; if (mapa_read !== 1'b0) begin errors++; $display("FAIL delayed_done_idle got %b want 0", mapa_read); end
    strict = 0;
    resp_delay = 0;
    load_model(0);
    for (int i = 0; i < 4; i++) begin
      x = int'($urandom_range(1, SW - 1));
      y = int'($urandom_range(0, 15));
      pix(x, y, c);
      checks++; if (c !== exp_buf[(y >> BB) % 2][x >> BB]) begin errors++; $display("FAIL delayed_random (%0d,%0d) got %0d want %0d", x, y, c, exp_buf[(y >> BB) % 2][x >> BB]); end
    end
  endtask

  task automatic test_underrun;
    bit ok;
    logic [CB-1:0] c;
    resp_en = 0;
    pix(0, 0, c);
    tick(3);
    checks++; if (mapa_read !== 1'b1 || mapa_x !== 10'd0 || mapa_y !== 10'd1) begin errors++; $display("FAIL stall_request got read=%b (%0d,%0d) want 1 (0,1)", mapa_read, mapa_x, mapa_y); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL pre_underrun got %b want 0", underrun); end
    pix(0, 8, c);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got %b want 1", underrun); end
    checks++; if (c !== exp_buf[1][0]) begin errors++; $display("FAIL underrun_cor got %0d want %0d", c, exp_buf[1][0]); end
    tick(1);
    checks++; if (mapa_read !== 1'b1 || mapa_x !== 10'd0 || mapa_y !== 10'd2) begin errors++; $display("FAIL underrun_restart got read=%b (%0d,%0d) want 1 (0,2)", mapa_read, mapa_x, mapa_y); end
    pulse_frame();
    tick(1);
    checks++; if (mapa_read !== 1'b1 || mapa_x !== 10'd0 || mapa_y !== 10'd0) begin errors++; $display("FAIL frame_restart got read=%b (%0d,%0d) want 1 (0,0)", mapa_read, mapa_x, mapa_y); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b want 1", underrun); end
    hs_q.delete();
    resp_en = 1;
    wait_hs(TX, ok);
    tick(4);
    checks++; if (!ok || seq_diff(0) !== 0) begin errors++; $display("FAIL resume_sequence diffs=%0d want 0 (n=%0d)", seq_diff(0), hs_q.size()); end
    load_model(0);
  endtask

  task automatic test_reset_mid_fetch;
    bit ok;
    bit found = 0;
    int b = 0;
    hs_q.delete();
    pulse_frame();
    while (!found && b < 60) begin
      if (mapa_read === 1'b1 && mapa_x === 10'd4) found = 1;
      else begin @(negedge clk); b++; end
    end
    checks++; if (!found) begin errors++; $display("FAIL reach_col4 got x=%0d want 4", mapa_x); end
    reset = 1'b1;
    pixel_read = 1'b1;
    pixel_x = 10'd17;
    pixel_y = 10'd3;
    @(negedge clk);
    checks++; if (mapa_read !== 1'b0) begin errors++; $display("FAIL midreset_read got %b want 0", mapa_read); end
    checks++; if (cor !== '0) begin errors++; $display("FAIL midreset_cor got %0d want 0", cor); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midreset_underrun got %b want 0", underrun); end
    checks++; if (mapa_x !== 10'd0 || mapa_y !== 10'd0) begin errors++; $display("FAIL midreset_addr got (%0d,%0d) want (0,0)", mapa_x, mapa_y); end
    reset = 1'b0;
    pixel_read = 1'b0;
    tick(1);
    hs_q.delete();
    tick(5);
    checks++; if (mapa_read !== 1'b0 || hs_q.size() !== 0) begin errors++; $display("FAIL midreset_idle got read=%b n=%0d want 0 0", mapa_read, hs_q.size()); end
    pulse_frame();
    wait_hs(TX, ok);
    tick(4);
    checks++; if (!ok || seq_diff(0) !== 0) begin errors++; $display("FAIL midreset_refetch diffs=%0d want 0 (n=%0d)", seq_diff(0), hs_q.size()); end
    load_model(0);
  endtask

  task automatic test_last_row;
    bit ok;
    logic [CB-1:0] c;
    int x, y;
    for (int r = 0; r < TY - 1; r++) begin
      hs_q.delete();
      pix(0, r * 8, c);
      checks++; if (c !== exp_buf[r % 2][0]) begin errors++; $display("FAIL frame_trig%0d_cor got %0d want %0d", r, c, exp_buf[r % 2][0]); end
      wait_hs(TX, ok);
      tick(4);
      checks++; if (!ok || seq_diff(r + 1) !== 0) begin errors++; $display("FAIL frame_row%0d_sequence diffs=%0d want 0", r + 1, seq_diff(r + 1)); end
      load_model(r + 1);
    end
    hs_q.delete();
    pix(0, 24, c);
    checks++; if (c !== exp_buf[1][0]) begin errors++; $display("FAIL last_trig_cor got %0d want %0d", c, exp_buf[1][0]); end
    tick(10);
    checks++; if (mapa_read !== 1'b0 || hs_q.size() !== 0) begin errors++; $display("FAIL last_row_no_request got read=%b n=%0d want 0 0", mapa_read, hs_q.size()); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL frame_underrun got %b want 0", underrun); end
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(1, SW - 1));
      y = int'($urandom_range(16, SH - 1));
      pix(x, y, c);
      checks++; if (c !== exp_buf[(y >> BB) % 2][x >> BB]) begin errors++; $display("FAIL rows23_random (%0d,%0d) got %0d want %0d", x, y, c, exp_buf[(y >> BB) % 2][x >> BB]); end
    end
    @(negedge clk);
    pixel_read = 1'b0;
    pixel_x = 10'($urandom_range(0, SW - 1));
    pixel_y = 10'($urandom_range(0, SH - 1));
    @(negedge clk);
    checks++; if (cor !== '0) begin errors++; $display("FAIL blank_cor got %0d want 0", cor); end
  endtask

  task automatic test_random_delay;
    bit ok;
    logic [CB-1:0] c;
    int x, y;
    rand_delay = 1;
    gap_err = 0;
    hs_q.delete();
    pulse_frame();
    wait_hs(TX, ok);
    tick(8);
    checks++; if (!ok || seq_diff(0) !== 0) begin errors++; $display("FAIL randdelay_sequence diffs=%0d want 0 (n=%0d)", seq_diff(0), hs_q.size()); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL randdelay_gap got %0d want 0", gap_err); end
    rand_delay = 0;
    load_model(0);
    for (int i = 0; i < 10; i++) begin
      x = int'($urandom_range(1, SW - 1));
      y = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(24, 31));
      pix(x, y, c);
      checks++; if (c !== exp_buf[(y >> BB) % 2][x >> BB]) begin errors++; $display("FAIL randdelay_pixel (%0d,%0d) got %0d want %0d", x, y, c, exp_buf[(y >> BB) % 2][x >> BB]); end
    end
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_row_trigger();
    test_delayed();
    test_underrun();
    test_reset_mid_fetch();
    test_last_row();
    test_random_delay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

endmodule
